product_accumulator: RTL and testbench

Downstream consumer of the `multiplier` stage. It takes the signed (M+N)-bit products one at a time through a valid/ready handshake and sums a programmable number of them into a wide accumulator. It then rounds and saturates the sum to a narrow signed result and holds that result on a valid/ready output until it is taken. This is the multiply-accumulate back end of the datapath, between the multiplier and the result sink.

---
 rtl/product_accumulator_pkg.sv | 23 ++
 rtl/product_accumulator_if.sv | 29 ++
 rtl/product_accumulator_round_sat.sv | 36 +++
 rtl/product_accumulator.sv | 107 ++++++++++
 tb/tb_product_accumulator.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/product_accumulator_pkg.sv
// Shared defaults and FSM encoding for the product accumulator
// and the output stages built on top of it.
package product_accumulator_pkg;

  localparam int DEF_M     = 26;
  localparam int DEF_N     = 14;
  localparam int DEF_LEN_W = 8;
  localparam int DEF_ACC_W = 48;
  localparam int DEF_SHIFT = 16;
  localparam int DEF_OUT_W = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    ROUND = 2'd2,
    HOLD  = 2'd3
  } acc_state_t;

  function automatic bit acc_w_ok(int m, int n, int len_w, int acc_w);
    return acc_w >= m + n + len_w;
  endfunction

endpackage

// File: rtl/product_accumulator_if.sv
// Product input and result output handshakes of the
// product accumulator.
interface product_accumulator_if
  import product_accumulator_pkg::*;
#(
  parameter int P_W   = DEF_M + DEF_N,
  parameter int LEN_W = DEF_LEN_W,
  parameter int OUT_W = DEF_OUT_W
);
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [P_W-1:0]   in_product;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_sat;
  logic             busy;

  modport master (
    output len, in_valid, in_product, out_ready,
    input  in_ready, out_valid, out_data, out_sat, busy
  );

  modport slave (
    input  len, in_valid, in_product, out_ready,
    output in_ready, out_valid, out_data, out_sat, busy
  );
endinterface

// File: rtl/product_accumulator_round_sat.sv
// Round-half-up and saturate a wide signed sum to OUT_W bits.
// Purely combinational, reused by later output stages.
module round_sat #(
  parameter int ACC_W = 48,
  parameter int SHIFT = 16,
  parameter int OUT_W = 24
) (
  input  logic [ACC_W-1:0] acc,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat
);
  localparam logic signed [ACC_W:0] HALF =
    {{(ACC_W+1-SHIFT){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
  localparam logic signed [ACC_W:0] MAXV =
    {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MINV =
    {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [ACC_W:0] sum;
  logic signed [ACC_W:0] r;

  // One guard bit keeps the rounding add from wrapping.
  always_comb begin
    sum      = $signed({acc[ACC_W-1], acc}) + HALF;
    r        = sum >>> SHIFT;
    out_sat  = 1'b0;
    out_data = r[OUT_W-1:0];
    if (r > MAXV) begin
      out_sat  = 1'b1;
      out_data = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (r < MINV) begin
      out_sat  = 1'b1;
      out_data = {1'b1, {(OUT_W-1){1'b0}}};
    end
  end
endmodule

// File: rtl/product_accumulator.sv
// Sums a framed run of signed products, then rounds, saturates
// and holds the result until the sink takes it.
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int M     = DEF_M,
  parameter int N     = DEF_N,
  parameter int LEN_W = DEF_LEN_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int SHIFT = DEF_SHIFT,
  parameter int OUT_W = DEF_OUT_W
) (
  input logic clk,
  input logic rst,
  product_accumulator_if.slave bus
);
  localparam int P_W = M + N;

  if (!acc_w_ok(M, N, LEN_W, ACC_W)) begin : g_chk
    $error("ACC_W too small for M+N+LEN_W");
  end

  acc_state_t       state, nxt;
  logic [ACC_W-1:0] acc;
  logic [LEN_W-1:0] cnt, target;
  logic [OUT_W-1:0] data_q, rs_data;
  logic             sat_q, rs_sat, valid_q;
  logic             in_ready, accept;
  logic [ACC_W-1:0] prod_x;
  logic [LEN_W-1:0] cnt_inc;

  assign prod_x  = {{(ACC_W-P_W){bus.in_product[P_W-1]}},
                    bus.in_product};
  assign cnt_inc = cnt + 1'b1;
  assign accept  = bus.in_valid && in_ready;

  round_sat #(
    .ACC_W(ACC_W),
    .SHIFT(SHIFT),
    .OUT_W(OUT_W)
  ) u_rs (
    .acc     (acc),
    .out_data(rs_data),
    .out_sat (rs_sat)
  );

  always_comb begin
    nxt      = state;
    in_ready = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (accept)
          nxt = (bus.len <= LEN_W'(1)) ? ROUND : ACC;
      end
      ACC: begin
        in_ready = 1'b1;
        if (accept && cnt_inc == target)
          nxt = ROUND;
      end
      ROUND: nxt = HOLD;
      HOLD: if (valid_q && bus.out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      cnt     <= '0;
      target  <= '0;
      data_q  <= '0;
      sat_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          acc    <= prod_x;
          cnt    <= LEN_W'(1);
          target <= (bus.len == '0) ? LEN_W'(1) : bus.len;
        end
        ACC: if (accept) begin
          acc <= acc + prod_x;
          cnt <= cnt_inc;
        end
        ROUND: begin
          data_q  <= rs_data;
          sat_q   <= rs_sat;
          valid_q <= 1'b1;
        end
        HOLD: if (valid_q && bus.out_ready) valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_sat   = sat_q;
  assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench for product_accumulator: vector table,
// corner-case sequences and random frames against a sum model.
module tb_product_accumulator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  product_accumulator_if bus ();

  product_accumulator dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    longint      prod;
    logic [23:0] exp_data;
    logic        exp_sat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model(input longint q[$],
                                output logic [23:0] d,
                                output logic s);
    longint sum = 0;
    longint r;
    foreach (q[i]) sum += q[i];
    r = (sum + 64'sd32768) >>> 16;
    s = 1'b1;
    if (r > 64'sd8388607)       d = 24'h7FFFFF;
    else if (r < -64'sd8388608) d = 24'h800000;
    else begin
      d = r[23:0];
      s = 1'b0;
    end
  endfunction

  // Feeds one frame; returns #1 after the edge that enters HOLD.
  task automatic feed(input int l, input longint q[$], input bit gaps);
    longint p;
    int t;
    foreach (q[i]) begin
      if (gaps && ($urandom % 3 == 0)) begin
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
      end
      p = q[i];
      bus.in_valid   = 1'b1;
      bus.in_product = p[39:0];
      bus.len        = (i == 0) ? 8'(l) : 8'($urandom);
      t = 0;
      while (!bus.in_ready && t < 50) begin
        @(posedge clk); #1;
        t++;
      end
      if (!bus.in_ready) check("accept_timeout", 0, 1);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    check("round_valid", bus.out_valid, 0);
    check("round_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    check("hold_valid", bus.out_valid, 1);
    check("hold_ready", bus.in_ready, 0);
  endtask

  task automatic collect(input string name, input logic [23:0] d,
                         input logic s);
    check({name, "_data"}, bus.out_data, d);
    check({name, "_sat"}, bus.out_sat, s);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({name, "_done"}, bus.out_valid, 0);
    check({name, "_idle"}, {bus.busy, bus.in_ready}, 2'b01);
  endtask

  task automatic frame(input string name, input int l,
                       input longint q[$], input bit gaps);
    logic [23:0] d;
    logic s;
    model(q, d, s);
    feed(l, q, gaps);
    collect(name, d, s);
  endtask

  vec_t vecs[8];
  longint q[$];
  longint p;

  initial begin
    bus.len = '0;
    bus.in_valid = 1'b0;
    bus.in_product = '0;
    bus.out_ready = 1'b0;

    vecs[0] = '{64'sh10000, 24'h000001, 1'b0};
    vecs[1] = '{64'sh8000, 24'h000001, 1'b0};
    vecs[2] = '{-64'sh8000, 24'h000000, 1'b0};
    vecs[3] = '{64'sh7FFF, 24'h000000, 1'b0};
    vecs[4] = '{-64'sh8001, 24'hFFFFFF, 1'b0};
    vecs[5] = '{-64'sh10000, 24'hFFFFFF, 1'b0};
    vecs[6] = '{64'sh7FFF8000, 24'h008000, 1'b0};
    vecs[7] = '{64'sh7FFFFFFFFF, 24'h7FFFFF, 1'b1};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", bus.in_ready, 1);
    check("rst_valid", bus.out_valid, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_busy", bus.busy, 0);

    foreach (vecs[i]) begin
      q = {vecs[i].prod};
      feed(1, q, 1'b0);
      collect($sformatf("vec%0d", i), vecs[i].exp_data,
              vecs[i].exp_sat);
    end

    q = {64'sh10000, 64'sh20000, -64'sh10000, 64'sh30000};
    feed(4, q, 1'b0);
    collect("len4", 24'd5, 1'b0);

    q = {64'sh30000};
    feed(0, q, 1'b0);
    collect("len0", 24'd3, 1'b0);

    q = {};
    repeat (255) q.push_back(64'sh7FFFFFFFFF);
    feed(255, q, 1'b0);
    collect("satpos", 24'h7FFFFF, 1'b1);

    q = {-64'sh8000000000, -64'sh8000000000};
    feed(2, q, 1'b0);
    collect("satneg", 24'h800000, 1'b1);

    q = {64'sh10000};
    feed(1, q, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_product = 40'h50000;
    bus.len = 8'd1;
    repeat (5) begin
      @(posedge clk); #1;
      check("stall_data", bus.out_data, 1);
      check("stall_ready", {bus.out_valid, bus.in_ready}, 2'b10);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("stall_release", {bus.out_valid, bus.busy, bus.in_ready},
          3'b001);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("stall_accept", {bus.busy, bus.out_valid}, 2'b10);
    @(posedge clk); #1;
    check("stall_next", {bus.out_valid, bus.out_data}, {1'b1, 24'd5});
    collect("stall", 24'd5, 1'b0);

    bus.len = 8'd4;
    bus.in_valid = 1'b1;
    bus.in_product = 40'h40000;
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("abort_busy", bus.busy, 1);
    rst = 1'b1;
    #1;
    check("abort_rst",
          {bus.busy, bus.in_ready, bus.out_valid, bus.out_sat,
           bus.out_data}, {4'b0100, 24'd0});
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    q = {64'sh10000};
    feed(1, q, 1'b0);
    collect("abort_fresh", 24'd1, 1'b0);

    for (int f = 0; f < 30; f++) begin
      int l;
      int n;
      l = $urandom_range(0, 8);
      n = (l == 0) ? 1 : l;
      q = {};
      for (int k = 0; k < n; k++) begin
        p = {$urandom, $urandom};
        p = (p <<< 24) >>> 24;
        if (f % 2 == 1) p = p >>> 14;
        q.push_back(p);
      end
      frame($sformatf("rnd%0d", f), l, q, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
